chip_step_sequencer: RTL
========================

// Module: chip_step_sequencer
// PURPOSE
//   Upstream driver of the generated process blocks: replaces the bench's step loop in hardware.
//   Issues one init cycle (step -1), then runs fixed-order single-threaded rounds.
//   Each round grants processes 0..PROCESSES-1 one cycle each, then pulses print.
//   Halts when any process stops or max_steps rounds complete; reports step count and return code.
// PARAMETERS
//   PROCESSES   4   number of process blocks sequenced (>=1)
//   PID_WIDTH   2   width of process_current; must be >= clog2(PROCESSES), >=1
//   STEP_WIDTH  16  width of step / max_steps counters (unsigned)
//   RC_WIDTH    8   width of each process return code
// PORTS
//   clock           in   1                    rising-edge clock
//   reset_n         in   1                    asynchronous, active-low reset
//   start           in   1                    begin a run; honoured in IDLE/DONE only
//   max_steps       in   STEP_WIDTH           round limit, sampled on accepted start
//   proc_stop       in   PROCESSES            per-process stop flags (registered by processes)
//   proc_rc         in   PROCESSES*RC_WIDTH   per-process return codes, process i at [i*RC_WIDTH +: RC_WIDTH]
//   init            out  1                    high for the single init cycle; processes clear state
//   proc_enable     out  PROCESSES            one-hot grant in RUN; all ones during init; else 0
//   process_current out  PID_WIDTH            index of granted process in RUN; 0 otherwise
//   step            out  STEP_WIDTH           completed rounds this run
//   print_strobe    out  1                    one-cycle pulse after each completed round
//   running         out  1                    high in INIT/RUN/PRINT
//   done            out  1                    high in DONE until next start
//   timed_out       out  1                    valid with done: 1 = max_steps reached without stop
//   return_code     out  RC_WIDTH             valid with done: rc of lowest-indexed stopped process, else 0
// BEHAVIOUR
//   Reset (async, any state, mid-run too): state=IDLE; every output 0; latched max_steps 0.
//   States: IDLE, INIT, RUN, PRINT, DONE (enum in chip_pkg).
//   IDLE/DONE + start -> INIT; latch max_steps; clear step, timed_out, return_code, done.
//   INIT (1 cycle): init=1, proc_enable=all ones. Then evaluate halt (below); no halt -> RUN, pid=0.
//   RUN: proc_enable=1<<pid, process_current=pid; pid==PROCESSES-1 -> PRINT, else pid+1.
//   PRINT (1 cycle): print_strobe=1, step<=step+1; then evaluate halt with the incremented step.
//   Halt check (on exit from INIT or PRINT): stop_any=|proc_stop.
//     stop_any -> DONE, timed_out=0, return_code=proc_rc of lowest set stop bit.
//     else step_next >= max_steps_latched -> DONE, timed_out=1, return_code=0.
//     Stop priority over timeout when both true.
//   Round length PROCESSES+1 cycles; proc_stop sampled only at halt check, so a stop raised
//     by the last process in its granted cycle is seen in the PRINT check of that round.
//   max_steps==0: INIT -> DONE, timed_out=1, step=0, no RUN/PRINT cycles.
//   step saturates at all ones (no wrap); max_steps=all ones therefore always terminates.
//   start while running ignored. start in DONE restarts; done drops on entering INIT.
//   done, timed_out, return_code, step held stable in DONE.
//   Outputs registered; no combinational input-to-output paths.
// STRUCTURE
//   chip_pkg: state enum, RC_WIDTH default, helper function lowest_set_index.
//   Single module; no sub-module (round-robin pid counter is inline).
// TESTING
//   P=4, max_steps=3, no stops -> 3 rounds, 3 print pulses, step=3, done, timed_out=1, rc=0.
//   P=4, max_steps=100, proc_stop[2]=1 with rc=7 during round 5 -> DONE after PRINT of round 5, step=5, timed_out=0, rc=7.
//   proc_stop[1] and [3] rise together, rc 4 and 9 -> return_code=4; stop+limit same round -> timed_out=0.
//   max_steps=0 -> init pulse, then done next cycle, step=0, no proc_enable after init.
//   reset_n low mid-RUN (pid=2) -> all outputs 0 immediately; start after release -> clean init.
//   start pulsed during RUN -> ignored; start in DONE -> new run, step restarts at 0.

Source files
------------

// File: rtl/chip_step_sequencer_pkg.sv
// Shared types and helpers for the step sequencer: state encoding and stop-priority lookup.
package chip_step_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StRun,
    StPrint,
    StDone
  } state_e;

  localparam int unsigned RcWidthDefault = 8;
  localparam int unsigned MaxProcesses   = 32;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic int unsigned lowest_set_index(input logic [MaxProcesses-1:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = MaxProcesses - 1; i >= 0; i--) begin
      if (vec[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/chip_step_sequencer_if.sv
// Control/status bundle between the bench-side controller (master) and the step sequencer (slave).
interface chip_step_sequencer_if #(
  parameter int unsigned PROCESSES  = 4,
  parameter int unsigned PID_WIDTH  = 2,
  parameter int unsigned STEP_WIDTH = 16,
  parameter int unsigned RC_WIDTH   = 8
);
  logic                          start;
  logic [STEP_WIDTH-1:0]         max_steps;
  logic [PROCESSES-1:0]          proc_stop;
  logic [PROCESSES*RC_WIDTH-1:0] proc_rc;

  logic                          init;
  logic [PROCESSES-1:0]          proc_enable;
  logic [PID_WIDTH-1:0]          process_current;
  logic [STEP_WIDTH-1:0]         step;
  logic                          print_strobe;
  logic                          running;
  logic                          done;
  logic                          timed_out;
  logic [RC_WIDTH-1:0]           return_code;

  modport master (
    output start, max_steps, proc_stop, proc_rc,
    input  init, proc_enable, process_current, step, print_strobe, running, done, timed_out,
           return_code
  );

  modport slave (
    input  start, max_steps, proc_stop, proc_rc,
    output init, proc_enable, process_current, step, print_strobe, running, done, timed_out,
           return_code
  );
endinterface

// File: rtl/chip_step_sequencer.sv
// Hardware step loop: one init cycle, then fixed-order rounds granting each process a cycle,
// a print pulse per round, and a halt on the first stop or when the round limit is reached.
module chip_step_sequencer
  import chip_step_sequencer_pkg::*;
#(
  parameter int unsigned PROCESSES  = 4,
  parameter int unsigned PID_WIDTH  = 2,
  parameter int unsigned STEP_WIDTH = 16,
  parameter int unsigned RC_WIDTH   = RcWidthDefault
) (
  input logic                  clock,
  input logic                  reset_n,
  chip_step_sequencer_if.slave bus
);

  state_e                state_q, state_d;
  logic [PID_WIDTH-1:0]  pid_q, pid_d;
  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic [STEP_WIDTH-1:0] max_q, max_d;
  logic                  timed_out_q, timed_out_d;
  logic [RC_WIDTH-1:0]   rc_q, rc_d;

  logic                  stop_any;
  int unsigned           stop_idx;
  logic [RC_WIDTH-1:0]   rc_sel;
  logic [STEP_WIDTH-1:0] step_inc;
  logic [STEP_WIDTH-1:0] halt_step;
  logic                  check_halt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      pid_q       <= '0;
      step_q      <= '0;
      max_q       <= '0;
      timed_out_q <= 1'b0;
      rc_q        <= '0;
    end else begin
      state_q     <= state_d;
      pid_q       <= pid_d;
      step_q      <= step_d;
      max_q       <= max_d;
      timed_out_q <= timed_out_d;
      rc_q        <= rc_d;
    end
  end

  always_comb begin
    stop_any = |bus.proc_stop;
    stop_idx = lowest_set_index(MaxProcesses'(bus.proc_stop));
    rc_sel   = '0;
    for (int i = 0; i < int'(PROCESSES); i++) begin
      if (unsigned'(i) == stop_idx) rc_sel = bus.proc_rc[i*RC_WIDTH +: RC_WIDTH];
    end
    // Saturate so an all-ones limit still terminates.
    step_inc  = (&step_q) ? step_q : step_q + 1'b1;
    halt_step = (state_q == StPrint) ? step_inc : step_q;
  end

  always_comb begin
    state_d     = state_q;
    pid_d       = pid_q;
    step_d      = step_q;
    max_d       = max_q;
    timed_out_d = timed_out_q;
    rc_d        = rc_q;
    check_halt  = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d     = StInit;
          max_d       = bus.max_steps;
          step_d      = '0;
          pid_d       = '0;
          timed_out_d = 1'b0;
          rc_d        = '0;
        end
      end
      StInit: check_halt = 1'b1;
      StRun: begin
        if (pid_q == PID_WIDTH'(PROCESSES - 1)) begin
          state_d = StPrint;
          pid_d   = '0;
        end else begin
          pid_d = pid_q + 1'b1;
        end
      end
      StPrint: begin
        step_d     = step_inc;
        check_halt = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (check_halt) begin
      if (stop_any) begin
        state_d     = StDone;
        timed_out_d = 1'b0;
        rc_d        = rc_sel;
      end else if (halt_step >= max_q) begin
        state_d     = StDone;
        timed_out_d = 1'b1;
        rc_d        = '0;
      end else begin
        state_d = StRun;
        pid_d   = '0;
      end
    end
  end

  // Outputs decode registered state only.
  always_comb begin
    bus.init            = (state_q == StInit);
    bus.proc_enable     = '0;
    bus.process_current = '0;
    if (state_q == StInit) begin
      bus.proc_enable = '1;
    end else if (state_q == StRun) begin
      bus.proc_enable     = PROCESSES'(1) << pid_q;
      bus.process_current = pid_q;
    end
    bus.step         = step_q;
    bus.print_strobe = (state_q == StPrint);
    bus.running      = (state_q == StInit) || (state_q == StRun) || (state_q == StPrint);
    bus.done         = (state_q == StDone);
    bus.timed_out    = timed_out_q;
    bus.return_code  = rc_q;
  end

endmodule
